// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and its
// downstream display stage: default widths, FSM encoding and unit codes.
package bin2bcd_pkg;

    localparam int BIN_WIDTH_DEF = 30;
    localparam int DIGITS_DEF    = 10;
    localparam int CNT_W_DEF     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Unit selectors consumed by the OLED character stage.
    localparam logic [2:0] UNIT_US  = 3'd6;
    localparam logic [2:0] UNIT_PCT = 3'd7;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
// Inputs 0..9 map to at most 12, so the 4-bit result never overflows.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Conditional add-3, 4-bit, carry discarded.
    assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Produces packed BCD digits and a leading-zero mask.
//
// Handshake: start is sampled only while busy=0 (IDLE); the edge that sees
// start=1 captures bin_in. busy is high in SHIFT and DONE, and any start seen
// during that time is dropped, not queued. done is a one-cycle pulse that
// rises on the same edge that updates bcd_out/digit_mask; those outputs then
// hold until the next done. dbg_state exposes the FSM state.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_WIDTH_DEF,
    parameter int DIGITS    = DIGITS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_mask,
    output logic [1:0]            dbg_state
);

    state_t               state;
    state_t               state_next;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [4*DIGITS-1:0]  bcd_work;
    logic [4*DIGITS-1:0]  bcd_adj;
    logic [CNT_W-1:0]     cnt;
    logic [DIGITS-1:0]    mask_next;
    logic                 last_shift;
    logic                 accept;
    logic                 shift_en;
    logic                 load_out;

    assign last_shift = (cnt == CNT_W'(BIN_WIDTH - 1));
    assign dbg_state  = state;

    // Per-digit add-3 correction applied to the working register each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_work[4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and datapath enables decoded from the current state.
    always_comb begin
        busy     = (state == SHIFT) || (state == DONE);
        accept   = (state == IDLE) && start;
        shift_en = (state == SHIFT);
        load_out = (state == DONE);
    end

    // Leading-zero mask: a digit is significant if it or any higher digit is
    // nonzero; the units digit is always shown.
    always_comb begin
        logic any_nz;
        any_nz    = 1'b0;
        mask_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz       = any_nz | (bcd_work[4*i +: 4] != 4'd0);
            mask_next[i] = any_nz;
        end
        mask_next[0] = 1'b1;
    end

    // Working registers, shift counter and the held result outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_reg  <= '0;
            bcd_work   <= '0;
            cnt        <= '0;
            bcd_out    <= '0;
            digit_mask <= DIGITS'(1);
            done       <= 1'b0;
        end else begin
            done <= load_out;
            if (accept) begin
                shift_reg <= bin_in;
                bcd_work  <= '0;
                cnt       <= '0;
            end
            if (shift_en) begin
                // Top bit of the adjusted digits falls off; cannot be set
                // when 10^DIGITS exceeds the input range.
                {bcd_work, shift_reg} <= {bcd_adj, shift_reg} << 1;
                cnt <= cnt + CNT_W'(1);
            end
            if (load_out) begin
                bcd_out    <= bcd_work;
                digit_mask <= mask_next;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed conversions, ignored starts, mid-run reset
// and a back-to-back run. Expected results are queued at acceptance and
// checked by an independent monitor on the falling clock edge.
module tb_bin2bcd_seq;

    localparam int BW  = 30;
    localparam int DG  = 10;
    localparam int LAT = 31;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            start = 1'b0;
    logic [BW-1:0]   bin_in = '0;
    logic            busy;
    logic            done;
    logic [4*DG-1:0] bcd_out;
    logic [DG-1:0]   digit_mask;
    logic [1:0]      dbg_state;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int busy_run = 0;

    logic [4*DG+DG-1:0] exp_q[$];
    int                 lat_q[$];
    logic [4*DG-1:0]    last_bcd;
    logic [DG-1:0]      last_mask;

    bin2bcd_seq dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .digit_mask (digit_mask),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [4*DG-1:0] ref_bcd(input longint v);
        logic [4*DG-1:0] r;
        r = '0;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [DG-1:0] ref_mask(input logic [4*DG-1:0] b);
        logic [DG-1:0] m;
        m = '0;
        for (int i = 0; i < DG; i++)
            if (b[4*i +: 4] != 4'd0)
                for (int j = 0; j <= i; j++) m[j] = 1'b1;
        m[0] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive a start that the DUT must accept and queue its expected result.
    task automatic issue(input logic [BW-1:0] v, input logic [4*DG-1:0] eb, input logic [DG-1:0] em);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        exp_q.push_back({em, eb});
        lat_q.push_back(edge_cnt);
        start  = 1'b0;
        bin_in = $urandom_range(0, 32'h3FFF_FFFF);
    endtask

    // Drive a start that the DUT must ignore.
    task automatic pulse_ignored(input logic [BW-1:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [4*DG+DG-1:0] e;
        int                 a;
        if (sys_rst) begin
            last_bcd  = '0;
            last_mask = DG'(1);
            busy_run  = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_length", 64'(busy_run), 64'(LAT));
                busy_run = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = lat_q.pop_front();
                    check("bcd_out", 64'(bcd_out), 64'(e[4*DG-1:0]));
                    check("digit_mask", 64'(digit_mask), 64'(e[4*DG +: DG]));
                    check("done_latency", 64'(edge_cnt - a), 64'(LAT));
                end
                last_bcd  = bcd_out;
                last_mask = digit_mask;
            end else begin
                check("bcd_hold", 64'(bcd_out), 64'(last_bcd));
                check("mask_hold", 64'(digit_mask), 64'(last_mask));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [BW-1:0]   v;
        logic [4*DG-1:0] eb;

        repeat (3) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_mask", 64'(digit_mask), 64'h001);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #1;

        // Directed conversions.
        issue(30'd114514, 40'h00_0011_4514, 10'h03F);
        drain();
        issue(30'd0, 40'h0, 10'h001);
        drain();
        issue(30'h3FFF_FFFF, 40'h10_7374_1823, 10'h3FF);
        drain();

        // Starts during SHIFT and during DONE are dropped.
        issue(30'd5000, 40'h5000, 10'h00F);
        repeat (9) @(posedge clk);
        #1;
        pulse_ignored(30'd777);
        for (int i = 0; i < 40; i++) begin
            if (dbg_state == 2'd2) break;
            @(posedge clk);
            #1;
        end
        check("reach_done_state", 64'(dbg_state), 64'd2);
        pulse_ignored(30'd777);
        issue(30'd777, 40'h777, 10'h007);
        drain();

        // Reset mid-conversion aborts without a done.
        issue(30'd99, 40'h99, 10'h003);
        repeat (14) @(posedge clk);
        #1;
        sys_rst = 1'b1;
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bcd", 64'(bcd_out), 64'd0);
        check("abort_mask", 64'(digit_mask), 64'h001);
        repeat (40) @(posedge clk);
        #1;
        issue(30'd42, 40'h42, 10'h003);
        drain();

        // Back-to-back at minimum spacing.
        for (int n = 0; n < 20; n++) begin
            v  = $urandom_range(0, 32'h3FFF_FFFF);
            eb = ref_bcd(longint'(v));
            issue(v, eb, ref_mask(eb));
            repeat (LAT) @(posedge clk);
            #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
